aes_inv_cipher: RTL and testbench
=================================

AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the round count; only 10 (AES-128) is legal, and any other value SHALL fail elaboration.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the ciphertext/key pair on in_data/in_key is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a new pair this cycle.
REQ-006 SHALL have port in_data, input, 128 bits: ciphertext; byte 0 is [127:120], column-major per FIPS-197.
REQ-007 SHALL have port in_key, input, 128 bits: cipher key (round key 0), same byte order as in_data.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds recovered plaintext.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes out_data.
REQ-010 SHALL have port out_data, output, 128 bits: plaintext, registered.
REQ-011 SHALL have port busy, output, 1 bit: high in every FSM state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND, ROUND and DONE; in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE).
REQ-013 SHALL treat in_valid&&in_ready at a rising edge as acceptance; it SHALL load the state register with in_data, the key register with in_key, set round counter to 1, and go to EXPAND.
REQ-014 SHALL ignore in_valid, in_data and in_key whenever in_ready=0.
REQ-015 EXPAND SHALL last 10 cycles; each cycle SHALL apply forward key schedule step key<=next(key,rcon[cnt]), with cnt counting 1..10.
REQ-016 On the 10th EXPAND edge, state SHALL become in_data XOR rk10, the FSM SHALL go to ROUND, and cnt SHALL reset to 1.
REQ-017 Each ROUND cycle SHALL apply InvShiftRows, then InvSubBytes, then AddRoundKey(rk[10-cnt]).
REQ-018 Each ROUND cycle SHALL apply InvMixColumns after AddRoundKey except when cnt==10.
REQ-019 The round key used in each ROUND cycle SHALL be derived from the held key by the inverse key schedule: w[i-4]=w[i]^f(w[i-1]) on word 0 with rcon[11-cnt], plain XOR on words 1..3.
REQ-020 After ROUND cnt==10, the FSM SHALL go to DONE with out_data=plaintext; out_valid SHALL rise exactly 20 rising edges after the accepting edge.
REQ-021 In DONE, out_data SHALL remain stable until out_valid&&out_ready; the FSM SHALL then return to IDLE on that edge.
REQ-022 in_ready SHALL rise on the cycle after the DONE-to-IDLE edge, giving no back-to-back acceptance on the release edge.
REQ-023 All GF(2^8) arithmetic SHALL be modulo x^8+x^4+x^3+x+1; cnt SHALL be 4 bits and SHALL never exceed 10.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, out_valid=0, out_data=0, busy=0, cnt=0, and the state and key registers to 0.
REQ-025 in_ready SHALL read 1 while in reset.
REQ-026 Reset mid-operation SHALL abort the operation with no output produced; the first edge after release SHALL be able to accept a new pair.

Configuration
REQ-027 Macro AES_INV_KEY_CACHE_EN: when defined, the block SHALL hold the last cipher key, its rk10 and a cache-valid bit; the cache-valid bit SHALL be cleared by reset.
REQ-028 With AES_INV_KEY_CACHE_EN defined, acceptance with a valid cache and in_key equal to the cached key SHALL skip EXPAND: it SHALL load state=in_data^rk10 and go directly to ROUND, making latency 10 edges.
REQ-029 With AES_INV_KEY_CACHE_EN defined, a non-matching key SHALL expand normally and update the cache on the 10th EXPAND edge.
REQ-030 Without AES_INV_KEY_CACHE_EN, there SHALL be no cache registers, and latency SHALL always be 20 edges.

Structure
REQ-031 Shared package aes_pkg SHALL hold the sbox and inv_sbox tables, the rcon table, xtime/gmul functions, and the NR and state-width constants; the encrypt side SHALL reuse it.
REQ-032 The inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns) SHALL be a combinational sub-module aes_inv_round.
REQ-033 The FSM, counter, key schedule step and registers SHALL reside in aes_inv_cipher.

Verification
REQ-034 Bench SHALL cover: key 2b7e1516_28aed2a6_abf71588_09cf4f3c with ct 3925841d_02dc09fb_dc118597_196a0b32 -> out 3243f6a8_885a308d_313198a2_e0370734, out_valid at edge 20.
REQ-035 Bench SHALL cover: key 00010203_04050607_08090a0b_0c0d0e0f with ct 69c4e0d8_6a7b0430_d8cdb780_70b4c55a -> out 00112233_44556677_8899aabb_ccddeeff.
REQ-036 Bench SHALL cover: out_ready held low 5 cycles -> out_data stable, in_ready=0, and a new in_valid ignored; then in_ready rises one cycle after release.
REQ-037 Bench SHALL cover: rst_n pulsed low at ROUND cnt=4 -> out_valid=0 immediately; the next vector decrypts correctly.
REQ-038 Bench SHALL cover (with AES_INV_KEY_CACHE_EN): the same key twice -> the second result arrives at edge 10; a changed key -> edge 20, with correct plaintext in both cases.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg -- shared AES definitions used by both the encrypt and decrypt sides.
// Holds the forward/inverse S-box tables, the round-constant table, the
// GF(2^8) helpers (xtime/gmul, modulo x^8+x^4+x^3+x+1), the AES-128 round
// count and the state width.
// No ports (package).
package aes_pkg;

    localparam int AES_NR      = 10;
    localparam int AES_STATE_W = 128;

    // Index 0 is the most significant byte of each concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Round constants for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply in GF(2^8).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round -- combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns.
// Ports:
//   i_state [127:0] : input state, byte 0 at [127:120], column-major
//   i_rkey  [127:0] : round key for this round, same byte order
//   i_mix           : 1 = apply InvMixColumns after AddRoundKey
//   o_state [127:0] : resulting state
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [AES_STATE_W-1:0] i_state,
    input  logic [AES_STATE_W-1:0] i_rkey,
    input  logic                   i_mix,
    output logic [AES_STATE_W-1:0] o_state
);

    logic [7:0] w_ark [16];
    logic [7:0] w_mix [16];

    // InvShiftRows (row r rotates right by r), InvSubBytes and AddRoundKey.
    always_comb begin
        for (int i = 0; i < 16; i++) w_ark[i] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_ark[c*4+r] = inv_sbox(i_state[127-8*((((c-r+4)%4)*4)+r) -: 8])
                             ^ i_rkey[127-8*(c*4+r) -: 8];
            end
        end
    end

    // InvMixColumns on each column of the post-AddRoundKey state.
    always_comb begin
        for (int i = 0; i < 16; i++) w_mix[i] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            w_mix[c*4+0] = gmul(w_ark[c*4+0], 8'h0e) ^ gmul(w_ark[c*4+1], 8'h0b)
                         ^ gmul(w_ark[c*4+2], 8'h0d) ^ gmul(w_ark[c*4+3], 8'h09);
            w_mix[c*4+1] = gmul(w_ark[c*4+0], 8'h09) ^ gmul(w_ark[c*4+1], 8'h0e)
                         ^ gmul(w_ark[c*4+2], 8'h0b) ^ gmul(w_ark[c*4+3], 8'h0d);
            w_mix[c*4+2] = gmul(w_ark[c*4+0], 8'h0d) ^ gmul(w_ark[c*4+1], 8'h09)
                         ^ gmul(w_ark[c*4+2], 8'h0e) ^ gmul(w_ark[c*4+3], 8'h0b);
            w_mix[c*4+3] = gmul(w_ark[c*4+0], 8'h0b) ^ gmul(w_ark[c*4+1], 8'h0d)
                         ^ gmul(w_ark[c*4+2], 8'h09) ^ gmul(w_ark[c*4+3], 8'h0e);
        end
    end

    // Flatten, skipping InvMixColumns on the final round.
    always_comb begin
        o_state = {AES_STATE_W{1'b0}};
        for (int i = 0; i < 16; i++) begin
            if (i_mix) o_state[127-8*i -: 8] = w_mix[i];
            else       o_state[127-8*i -: 8] = w_ark[i];
        end
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher -- iterative AES-128 decryptor, one round per clock.
// The forward key schedule runs for 10 cycles (EXPAND) to reach rk10, then
// each ROUND cycle steps the key schedule backwards while decrypting.
// Optional macro AES_INV_KEY_CACHE_EN keeps the last key and its rk10 so a
// repeated key skips EXPAND (latency 10 edges instead of 20).
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid / in_ready / in_data[127:0] / in_key[127:0] : ciphertext + key in
//   out_valid / out_ready / out_data[127:0]              : plaintext out (registered)
//   busy                                                 : FSM not in IDLE
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic [AES_STATE_W-1:0] in_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    if (NR != 10) begin : g_nr_check
        $error("aes_inv_cipher: only NR=10 (AES-128) is supported");
    end

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_ROUND  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]             r_fsm;
    logic [3:0]             r_cnt;
    logic [AES_STATE_W-1:0] r_state;
    logic [AES_STATE_W-1:0] r_key;
    logic [AES_STATE_W-1:0] r_out;

    logic [AES_STATE_W-1:0] w_key_fwd;
    logic [AES_STATE_W-1:0] w_key_inv;
    logic [AES_STATE_W-1:0] w_round;
    logic                   w_cache_hit;
    logic [AES_STATE_W-1:0] w_cache_rk10;

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one schedule step: recover the old words 3..1 by XOR, then word 0.
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    assign w_key_fwd = key_fwd(r_key, rcon(r_cnt));
    // In ROUND cnt, r_key holds rk[11-cnt]; stepping back yields rk[10-cnt].
    assign w_key_inv = key_inv(r_key, rcon(4'd11 - r_cnt));

    aes_inv_round u_round (
        .i_state (r_state),
        .i_rkey  (w_key_inv),
        .i_mix   (r_cnt != 4'd10),
        .o_state (w_round)
    );

`ifdef AES_INV_KEY_CACHE_EN
    logic [AES_STATE_W-1:0] r_cache_key;
    logic [AES_STATE_W-1:0] r_cache_rk10;
    logic                   r_cache_vld;

    assign w_cache_hit  = r_cache_vld && (in_key == r_cache_key);
    assign w_cache_rk10 = r_cache_rk10;

    // Key cache: capture the key on a missing acceptance, validate at end of EXPAND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_key  <= {AES_STATE_W{1'b0}};
            r_cache_rk10 <= {AES_STATE_W{1'b0}};
            r_cache_vld  <= 1'b0;
        end else if (r_fsm == S_IDLE && in_valid && !w_cache_hit) begin
            r_cache_key  <= in_key;
            r_cache_vld  <= 1'b0;
        end else if (r_fsm == S_EXPAND && r_cnt == 4'd10) begin
            r_cache_rk10 <= w_key_fwd;
            r_cache_vld  <= 1'b1;
        end else begin
            r_cache_vld  <= r_cache_vld;
        end
    end
`else
    assign w_cache_hit  = 1'b0;
    assign w_cache_rk10 = {AES_STATE_W{1'b0}};
`endif

    // Main FSM, round counter, state/key datapath and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= 4'd0;
            r_state <= {AES_STATE_W{1'b0}};
            r_key   <= {AES_STATE_W{1'b0}};
            r_out   <= {AES_STATE_W{1'b0}};
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt <= 4'd1;
                        if (w_cache_hit) begin
                            r_state <= in_data ^ w_cache_rk10;
                            r_key   <= w_cache_rk10;
                            r_fsm   <= S_ROUND;
                        end else begin
                            r_state <= in_data;
                            r_key   <= in_key;
                            r_fsm   <= S_EXPAND;
                        end
                    end
                end
                S_EXPAND: begin
                    r_key <= w_key_fwd;
                    if (r_cnt == 4'd10) begin
                        // r_state still holds the ciphertext: initial AddRoundKey(rk10).
                        r_state <= r_state ^ w_key_fwd;
                        r_cnt   <= 4'd1;
                        r_fsm   <= S_ROUND;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                S_ROUND: begin
                    r_key   <= w_key_inv;
                    r_state <= w_round;
                    if (r_cnt == 4'd10) begin
                        r_out <= w_round;
                        r_cnt <= 4'd0;
                        r_fsm <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_fsm <= S_IDLE;
                end
                default: begin
                    r_fsm <= S_IDLE;
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign busy      = (r_fsm != S_IDLE);
    assign out_data  = r_out;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb_aes_inv_cipher -- scoreboard bench for aes_inv_cipher: FIPS-197 vectors,
// latency, output back-pressure, mid-operation reset and (with
// AES_INV_KEY_CACHE_EN) the key-cache fast path.
module tb_aes_inv_cipher;

`ifdef AES_INV_KEY_CACHE_EN
    localparam int HIT_LAT = 10;
`else
    localparam int HIT_LAT = 20;
`endif

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [127:0] q_pt  [$];
    int           q_lat [$];

    aes_inv_cipher #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: drive, wait for out_valid, score, optionally stall, release.
    task automatic run(input logic [127:0] key, input logic [127:0] ct,
                       input logic [127:0] pt, input int lat, input int stall);
        int           edges;
        logic [127:0] exp_pt;
        int           exp_lat;
        logic [127:0] held;
        @(negedge clk);
        chk("in_ready_idle", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_key   = key;
        in_data  = ct;
        q_pt.push_back(pt);
        q_lat.push_back(lat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_key   = 128'd0;
        in_data  = 128'd0;
        edges    = 0;
        chk("busy_after_accept", 128'(busy), 128'd1);
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("out_valid_seen", 128'(out_valid), 128'd1);
        exp_pt  = q_pt.pop_front();
        exp_lat = q_lat.pop_front();
        chk("latency", 128'(edges), 128'(exp_lat));
        chk("plaintext", out_data, exp_pt);
        chk("in_ready_done", 128'(in_ready), 128'd0);
        held = out_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = ~ct;
            in_key   = ~key;
            @(posedge clk);
            #1;
            chk("stall_data_stable", out_data, held);
            chk("stall_valid", 128'(out_valid), 128'd1);
            chk("stall_in_ready", 128'(in_ready), 128'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid_low", 128'(out_valid), 128'd0);
        chk("release_in_ready", 128'(in_ready), 128'd1);
        chk("release_not_busy", 128'(busy), 128'd0);
        in_valid = 1'b0;
        in_data  = 128'd0;
        in_key   = 128'd0;
    endtask

    // Accept a vector, reset once ROUND cnt=4, check the abort.
    task automatic abort_at_round4(input logic [127:0] key, input logic [127:0] ct);
        @(negedge clk);
        in_valid = 1'b1;
        in_key   = key;
        in_data  = ct;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("busy_mid_round", 128'(busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_out_data", out_data, 128'd0);
        q_pt.delete();
        q_lat.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 128'd0;
        in_key    = 128'd0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        run(K1, C1, P1, 20, 0);
        run(K2, C2, P2, 20, 0);
        run(K2, C2, P2, HIT_LAT, 0);
        run(K1, C1, P1, 20, 5);
        abort_at_round4(K2, C2);
        run(K1, C1, P1, 20, 0);
        run(K1, C1, P1, HIT_LAT, 0);
        run(K2, C2, P2, 20, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
